// File: rtl/mips_cpu_regfile_pkg.sv
// Shared types and the partial-load merge function for the register file.
// Both the write path and the bypass path use this one merge function.
package mips_cpu_regfile_pkg;

  typedef enum logic [2:0] {
    WR_WORD = 3'd0,
    WR_LB   = 3'd1,
    WR_LBU  = 3'd2,
    WR_LH   = 3'd3,
    WR_LHU  = 3'd4,
    WR_LWL  = 3'd5,
    WR_LWR  = 3'd6,
    WR_RSVD = 3'd7
  } wr_op_e;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;

  typedef struct packed {
    logic [31:0] val;
    logic        suppress;
  } merge_t;

  function automatic merge_t merge_word(
    input logic [31:0] old,
    input logic [31:0] d,
    input wr_op_e      op,
    input logic [1:0]  b
  );
    merge_t      m;
    logic [7:0]  by;
    logic [15:0] hw;
    by = d[{b, 3'b000} +: 8];
    hw = b[1] ? d[31:16] : d[15:0];
    m.val = d;
    m.suppress = 1'b0;
    case (op)
      WR_LB:  m.val = {{24{by[7]}}, by};
      WR_LBU: m.val = {24'h0, by};
      WR_LH: begin
        m.val = {{16{hw[15]}}, hw};
        m.suppress = b[0];
      end
      WR_LHU: begin
        m.val = {16'h0, hw};
        m.suppress = b[0];
      end
      WR_LWL: begin
        case (b)
          2'd0: m.val = {d[7:0], old[23:0]};
          2'd1: m.val = {d[15:0], old[15:0]};
          2'd2: m.val = {d[23:0], old[7:0]};
          default: m.val = d;
        endcase
      end
      WR_LWR: begin
        case (b)
          2'd0: m.val = d;
          2'd1: m.val = {old[31:24], d[31:8]};
          2'd2: m.val = {old[31:16], d[31:16]};
          default: m.val = {old[31:8], d[31:24]};
        endcase
      end
      default: m.val = d;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mips_cpu_regfile_sb_if.sv
// Decode/writeback side bundle of the scoreboarded register file.
// master = core driving reads/writes/issues, slave = register file.
interface mips_cpu_regfile_sb_if #(
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*32-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NRD-1:0]    rd_use;
  logic              stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [31:0]       wr_data;
  logic [2:0]        wr_op;
  logic [1:0]        wr_vaddr;
  logic              wr_ld_done;
  logic              ld_issue;
  logic [AW-1:0]     ld_dest;
  logic              err_misalign;
  logic [31:0]       regv0;

  modport master (
    output rd_addr, rd_use,
    output wr_en, wr_addr, wr_data,
    output wr_op, wr_vaddr, wr_ld_done,
    output ld_issue, ld_dest,
    input  rd_data, rd_busy, stall,
    input  err_misalign, regv0
  );

  modport slave (
    input  rd_addr, rd_use,
    input  wr_en, wr_addr, wr_data,
    input  wr_op, wr_vaddr, wr_ld_done,
    input  ld_issue, ld_dest,
    output rd_data, rd_busy, stall,
    output err_misalign, regv0
  );

endinterface

// File: rtl/mips_cpu_load_merge.sv
// Combinational partial-load merge: (old, data, op, vaddr) -> (new, suppress).
// One instance feeds both the register write and the read bypass.
module mips_cpu_load_merge
  import mips_cpu_regfile_pkg::*;
(
  input  logic [31:0] old_val,
  input  logic [31:0] data,
  input  logic [2:0]  op,
  input  logic [1:0]  vaddr,
  output logic [31:0] new_val,
  output logic        suppress
);

  merge_t m;

  always_comb begin
    m = merge_word(old_val, data, wr_op_e'(op), vaddr);
  end

  assign new_val  = m.val;
  assign suppress = m.suppress;

endmodule

// File: rtl/mips_cpu_regfile_sb.sv
// Multi-port register file with write-through bypass, load merge unit
// and a per-register pending-load scoreboard.
module mips_cpu_regfile_sb
  import mips_cpu_regfile_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter bit BYPASS = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_cpu_regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] R0 = REG_ZERO[AW-1:0];

  logic [NREG-1:0][31:0] regs;
  logic [NREG-1:0]       busy;
  logic                  err_q;

  logic [31:0] old_val;
  logic [31:0] mrg_val;
  logic        mrg_sup;
  logic        wr_fire;
  logic        ld_done;

  assign old_val = regs[bus.wr_addr];

  mips_cpu_load_merge u_merge (
    .old_val  (old_val),
    .data     (bus.wr_data),
    .op       (bus.wr_op),
    .vaddr    (bus.wr_vaddr),
    .new_val  (mrg_val),
    .suppress (mrg_sup)
  );

  assign wr_fire = bus.wr_en && (bus.wr_addr != R0) && !mrg_sup;
  assign ld_done = bus.wr_en && bus.wr_ld_done;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          done_hit;
    assign ra       = bus.rd_addr[k*AW +: AW];
    assign hit      = BYPASS && wr_fire && (bus.wr_addr == ra);
    assign done_hit = BYPASS && ld_done && (bus.wr_addr == ra);
    assign bus.rd_data[k*32 +: 32] =
      (ra == R0) ? 32'h0 :
      hit        ? mrg_val :
                   regs[ra];
    assign bus.rd_busy[k] = busy[ra] & ~done_hit;
  end

  assign bus.stall        = |(bus.rd_busy & bus.rd_use);
  assign bus.err_misalign = err_q;

  if (NREG > REG_V0) begin : g_v0
    assign bus.regv0 = regs[REG_V0[AW-1:0]];
  end else begin : g_no_v0
    assign bus.regv0 = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_fire) regs[bus.wr_addr] <= mrg_val;
      err_q <= bus.wr_en && mrg_sup;
    end
  end

  // Issue is applied after the clear so a same-cycle issue wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (ld_done) busy[bus.wr_addr] <= 1'b0;
      if (bus.ld_issue && bus.ld_dest != R0)
        busy[bus.ld_dest] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
// Directed bench for the scoreboarded register file.
// Inputs change 1 time unit after posedge; outputs sampled 1 unit later.
module tb_mips_cpu_regfile_sb;

  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mips_cpu_regfile_sb_if #(.NREG(NREG), .NRD(NRD)) bus ();

  mips_cpu_regfile_sb #(.NREG(NREG), .NRD(NRD), .BYPASS(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_op      = 3'd0;
    bus.wr_vaddr   = 2'd0;
    bus.wr_ld_done = 1'b0;
    bus.ld_issue   = 1'b0;
    bus.ld_dest    = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [2:0] op, input logic [1:0] va,
                    input logic done);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = a;
    bus.wr_data    = d;
    bus.wr_op      = op;
    bus.wr_vaddr   = va;
    bus.wr_ld_done = done;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.ld_issue = 1'b1;
    bus.ld_dest  = a;
  endtask

  task automatic rsel(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr[0 +: AW]  = a0;
    bus.rd_addr[AW +: AW] = a1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  function automatic logic [31:0] rd0();
    return bus.rd_data[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rd_data[63:32];
  endfunction

  initial begin
    idle();
    bus.rd_use = '0;
    rsel(5'd5, 5'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rd", rd0(), 32'h0);
    chk("rst_busy", 32'(bus.rd_busy), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_v0", bus.regv0, 32'h0);
    chk("rst_err", 32'(bus.err_misalign), 32'h0);
    rst_n = 1'b1;
    step();

    wr(5'd5, 32'hDEADBEEF, 3'd0, 2'd0, 1'b0);
    #1 chk("byp_r5", rd0(), 32'hDEADBEEF);
    step();
    chk("st_r5", rd0(), 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", rd0(), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    rsel(5'd8, 5'd9);
    wr(5'd8, 32'h11223344, 3'd0, 2'd0, 1'b0);
    step();
    wr(5'd9, 32'h55667788, 3'd0, 2'd0, 1'b0);
    step();
    wr(5'd8, 32'hAABBCCDD, 3'd5, 2'd1, 1'b0);
    #1 chk("lwl_byp", rd0(), 32'hCCDD3344);
    step();
    chk("lwl_st", rd0(), 32'hCCDD3344);
    wr(5'd9, 32'hAABBCCDD, 3'd6, 2'd2, 1'b0);
    #1 chk("lwr_byp", rd1(), 32'h5566AABB);
    step();
    chk("lwr_st", rd1(), 32'h5566AABB);

    rsel(5'd10, 5'd0);
    wr(5'd10, 32'h80FF0000, 3'd1, 2'd3, 1'b0);
    step();
    chk("lb", rd0(), 32'hFFFFFF80);
    wr(5'd10, 32'h80FF0000, 3'd2, 2'd3, 1'b0);
    step();
    chk("lbu", rd0(), 32'h00000080);
    wr(5'd10, 32'h80FF0000, 3'd4, 2'd2, 1'b0);
    step();
    chk("lhu", rd0(), 32'h000080FF);
    wr(5'd10, 32'h80FF0000, 3'd3, 2'd2, 1'b0);
    step();
    chk("lh", rd0(), 32'hFFFF80FF);
    wr(5'd10, 32'h1234ABCD, 3'd7, 2'd1, 1'b0);
    step();
    chk("rsvd_word", rd0(), 32'h1234ABCD);

    rsel(5'd4, 5'd0);
    wr(5'd4, 32'h00001234, 3'd0, 2'd0, 1'b0);
    step();
    issue(5'd4);
    step();
    chk("r4_busy", 32'(bus.rd_busy), 32'h1);
    chk("r4_err0", 32'(bus.err_misalign), 32'h0);
    wr(5'd4, 32'hFFFFFFFF, 3'd3, 2'd1, 1'b1);
    #1 chk("mis_byp", rd0(), 32'h00001234);
    chk("mis_busy_rel", 32'(bus.rd_busy), 32'h0);
    step();
    chk("mis_keep", rd0(), 32'h00001234);
    chk("mis_err1", 32'(bus.err_misalign), 32'h1);
    chk("mis_busy_clr", 32'(bus.rd_busy), 32'h0);
    step();
    chk("mis_err_end", 32'(bus.err_misalign), 32'h0);
    wr(5'd0, 32'h0, 3'd4, 2'd3, 1'b0);
    step();
    chk("mis_err_r0", 32'(bus.err_misalign), 32'h1);

    rsel(5'd0, 5'd3);
    bus.rd_use = 2'b10;
    issue(5'd3);
    step();
    chk("ld_stall_a", 32'(bus.stall), 32'h1);
    step();
    chk("ld_stall_b", 32'(bus.stall), 32'h1);
    bus.rd_use = 2'b01;
    #1 chk("no_use", 32'(bus.stall), 32'h0);
    bus.rd_use = 2'b10;
    bus.wr_en = 1'b0;
    bus.wr_ld_done = 1'b1;
    bus.wr_addr = 5'd3;
    #1 chk("done_noen", 32'(bus.stall), 32'h1);
    step();
    chk("done_noen_q", 32'(bus.rd_busy), 32'h2);
    wr(5'd3, 32'hCAFEF00D, 3'd0, 2'd0, 1'b1);
    #1 chk("cmp_stall", 32'(bus.stall), 32'h0);
    chk("cmp_data", rd1(), 32'hCAFEF00D);
    step();
    chk("cmp_busy", 32'(bus.rd_busy), 32'h0);
    issue(5'd3);
    step();
    issue(5'd3);
    wr(5'd3, 32'h00000777, 3'd0, 2'd0, 1'b1);
    #1 chk("both_comb", 32'(bus.rd_busy), 32'h0);
    step();
    chk("both_busy", 32'(bus.rd_busy), 32'h2);
    chk("both_data", rd1(), 32'h00000777);
    wr(5'd3, 32'h0, 3'd0, 2'd0, 1'b1);
    step();
    bus.rd_use = '0;

    rsel(5'd0, 5'd2);
    wr(5'd0, 32'hFFFFFFFF, 3'd0, 2'd0, 1'b0);
    issue(5'd0);
    #1 chk("r0_byp", rd0(), 32'h0);
    step();
    chk("r0_st", rd0(), 32'h0);
    chk("r0_busy", 32'(bus.rd_busy), 32'h0);
    wr(5'd2, 32'h7, 3'd0, 2'd0, 1'b0);
    #1 chk("v0_pre", bus.regv0, 32'h0);
    step();
    chk("v0_post", bus.regv0, 32'h7);
    chk("v0_rd", rd1(), 32'h7);

    rsel(5'd6, 5'd0);
    issue(5'd6);
    step();
    chk("r6_busy", 32'(bus.rd_busy), 32'h1);
    rst_n = 1'b0;
    #1 chk("r6_rst", 32'(bus.rd_busy), 32'h0);
    step();
    rst_n = 1'b1;
    wr(5'd6, 32'h00000066, 3'd0, 2'd0, 1'b1);
    step();
    chk("r6_plain", rd0(), 32'h00000066);
    chk("r6_free", 32'(bus.rd_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_regfile_sb.md
Name: mips_cpu_regfile_sb

Overview:
Parametrised successor to the CPU register file. Adds N read ports, a posedge write with same-cycle write-through bypass, and a built-in partial-load merge unit (LB/LBU/LH/LHU/LWL/LWR). Adds a per-register pending-load scoreboard that raises a stall when a read hits a register whose load has not returned. Sits between decode (reads, load issue) and writeback (write port) in the multi-cycle/pipelined core.

Parameters:
NREG, 32, number of registers; power of two, >=2; register 0 hardwired to zero
NRD, 2, number of combinational read ports (1..4)
BYPASS, 1, 1 = write-through forwarding to read ports in the write cycle; 0 = reads return stored value only

Ports:
clk  in  1  single clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
rd_addr  in  NRD*AW  packed read selectors, port k at [k*AW +: AW]; AW = $clog2(NREG)
rd_data  out  NRD*32  packed read data, port k at [k*32 +: 32]
rd_busy  out  NRD  port k's register has a pending load
stall  out  1  OR of rd_busy over ports flagged by rd_use
rd_use  in  NRD  port k is actually consumed by the current instruction
wr_en  in  1  write-port enable
wr_addr  in  AW  write destination
wr_data  in  32  raw write data (full memory word for loads)
wr_op  in  3  merge mode: 0 WORD, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved (treated as WORD)
wr_vaddr  in  2  byte offset for partial modes
wr_ld_done  in  1  this write completes an outstanding load; clears busy
ld_issue  in  1  a load targeting ld_dest is issued this cycle
ld_dest  in  AW  destination of the issued load
err_misalign  out  1  registered one-cycle pulse: LH/LHU with wr_vaddr[0]=1
regv0  out  32  debug: current stored value of register 2

Behaviour:
- Reset (rst_n low, async): all registers = 0, all busy bits = 0, err_misalign = 0. rd_data then reads 0, rd_busy = 0, stall = 0, regv0 = 0. Reset mid-load drops the pending load; a later wr_ld_done for it is a plain write.
- Read: combinational. rd_data[k] = merged write value if BYPASS && wr_en && wr_addr==rd_addr[k] && wr_addr!=0 && write not suppressed; otherwise stored value. Address 0 always reads 0.
- Write: posedge clk, when wr_en && wr_addr!=0 && not suppressed; new value = merge(old, wr_data, wr_op, wr_vaddr).
- Merge, with b = wr_vaddr:
  - WORD: wr_data.
  - LB/LBU: byte b of wr_data (byte 0 = [7:0]), sign-extended for LB, zero-extended for LBU.
  - LH/LHU: b=0 uses [15:0], b=2 uses [31:16], sign- or zero-extended. b odd: write suppressed and err_misalign=1 next cycle (even if wr_addr=0).
  - LWL: b=0 -> old[31:24]=d[7:0]; b=1 -> old[31:16]=d[15:0]; b=2 -> old[31:8]=d[23:0]; b=3 -> full d. Untouched bits keep the old value.
  - LWR: b=0 -> full d; b=1 -> old[23:0]=d[31:8]; b=2 -> old[15:0]=d[31:16]; b=3 -> old[7:0]=d[31:24].
  - "old" is the stored value before this edge.
- Scoreboard, one busy bit per register; bit 0 is constant 0:
  - ld_issue && ld_dest!=0: set busy[ld_dest] at posedge.
  - wr_en && wr_ld_done: clear busy[wr_addr] at posedge. The clear applies even if the write is suppressed by misalignment, so the core does not deadlock.
  - Issue and clear on the same register in the same cycle: issue wins; busy stays 1.
  - Issue to an already-busy register: stays busy. There is no counting; the core guarantees one outstanding load per register.
  - rd_busy[k] = busy[rd_addr[k]] & ~(wr_en & wr_ld_done & wr_addr==rd_addr[k]). The same-cycle completion releases the stall, matching bypass; with BYPASS=0 the completion term is omitted.
- wr_en=0 with wr_ld_done=1: ignored.
- Latency: read 0 cycles; write visible combinationally via bypass, stored at the next posedge; err_misalign 1 cycle.

Decomposition:
- Package mips_cpu_regfile_pkg: wr_op enum (WR_WORD..WR_LWR), REG_ZERO and REG_V0 constants, and a merge function.
- One natural sub-module, mips_cpu_load_merge: combinational (old, data, op, vaddr) -> (new, suppress). It is shared by the write path and the bypass path so both compute identical values.

Test Plan:
- Reset, then write WORD 0xDEADBEEF to r5 and read r5 on port 0 in the same cycle -> rd_data = 0xDEADBEEF (bypass); next cycle stored value is the same; assert rst_n low mid-cycle -> all reads 0 immediately.
- r8 = 0x11223344, then LWL with data 0xAABBCCDD, vaddr=1 -> r8 = 0xCCDD3344. LWR with vaddr=2 on r9 = 0x55667788 -> r9 = 0x5566AABB.
- LB vaddr=3 with data 0x80FF0000 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU vaddr=2 -> 0x000080FF.
- LH vaddr=1 to r4 (holding 0x1234) with wr_ld_done -> r4 unchanged, err_misalign pulses exactly one cycle, busy[4] cleared.
- ld_issue r3, then read r3 with rd_use=1 -> stall=1 each cycle. Completion cycle with wr_ld_done -> stall=0, rd_data = loaded value. Same-cycle issue and complete on r3 -> busy stays 1.
- Write 0xFFFFFFFF to r0 and ld_issue r0 -> reads 0, rd_busy 0. Write r2 = 7 -> regv0 = 7 after the edge.
